// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - Multi-read-port integer register file with write bypass, clearing sweep and busy scoreboard.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                we,
    input  logic [AW-1:0]       wraddr,
    input  logic [XLEN-1:0]     wrdata,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic running;
    logic wr_ok;
    logic iss_ok;

    assign running = (state == RUN);
    assign wr_ok   = running && we && !((ZERO_REG != 0) && (wraddr == '0));
    assign iss_ok  = running && iss_en && !((ZERO_REG != 0) && (iss_rd == '0));

    // Sweep counter walks every entry once; ready is registered so it rises the cycle after the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset so it maps onto RAM; the sweep provides the zero contents.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[cnt] <= '0;
        end else if (wr_ok) begin
            regs[wraddr] <= wrdata;
        end
    end

    // Issue is applied after the writeback clear so a new producer wins on the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (running) begin
            if (flush) begin
                busy <= '0;
            end else begin
                if (wr_ok) begin
                    busy[wraddr] <= 1'b0;
                end
                if (iss_ok) begin
                    busy[iss_rd] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_port
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          hit;

        assign addr    = rs_addr[g*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = wr_ok && (wraddr == addr);

        assign rd_data[g*XLEN +: XLEN] = (!running || is_zero) ? '0 :
                                         hit                   ? wrdata :
                                                                 regs[addr];
        assign rd_busy[g] = running && busy[addr] && !hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - Directed self-checking bench for regfile_mp (default and 4-port/64-bit/16-entry configurations).
module tb_regfile_mp;

    logic clk;
    int   vectors;
    int   miscompares;

    logic        a_rst_n, a_ready, a_we, a_iss_en, a_flush;
    logic [4:0]  a_wraddr, a_iss_rd;
    logic [31:0] a_wrdata;
    logic [9:0]  a_rs_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;

    logic         b_rst_n, b_ready, b_we, b_iss_en, b_flush;
    logic [3:0]   b_wraddr, b_iss_rd;
    logic [63:0]  b_wrdata;
    logic [15:0]  b_rs_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;

    regfile_mp u_a (
        .clk     (clk),
        .rst_n   (a_rst_n),
        .ready   (a_ready),
        .we      (a_we),
        .wraddr  (a_wraddr),
        .wrdata  (a_wrdata),
        .rs_addr (a_rs_addr),
        .rd_data (a_rd_data),
        .rd_busy (a_rd_busy),
        .iss_en  (a_iss_en),
        .iss_rd  (a_iss_rd),
        .flush   (a_flush)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) u_b (
        .clk     (clk),
        .rst_n   (b_rst_n),
        .ready   (b_ready),
        .we      (b_we),
        .wraddr  (b_wraddr),
        .wrdata  (b_wrdata),
        .rs_addr (b_rs_addr),
        .rd_data (b_rd_data),
        .rd_busy (b_rd_busy),
        .iss_en  (b_iss_en),
        .iss_rd  (b_iss_rd),
        .flush   (b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        a_rst_n = 1'b0; a_we = 1'b0; a_wraddr = '0; a_wrdata = '0;
        a_rs_addr = '0; a_iss_en = 1'b0; a_iss_rd = '0; a_flush = 1'b0;
        b_rst_n = 1'b0; b_we = 1'b0; b_wraddr = '0; b_wrdata = '0;
        b_rs_addr = '0; b_iss_en = 1'b0; b_iss_rd = '0; b_flush = 1'b0;
        step();
        step();
        check("reset_ready_a", 64'(a_ready), 64'd0);
        check("reset_ready_b", 64'(b_ready), 64'd0);
        check("reset_busy_a", 64'(a_rd_busy), 64'd0);

        // Sweep: writes, issues and bypass attempts to reg 5 must be ignored
        a_we = 1'b1; a_wraddr = 5'd5; a_wrdata = 32'hDEAD;
        a_iss_en = 1'b1; a_iss_rd = 5'd5;
        a_rs_addr = {5'd5, 5'd5};
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("init_ready_a", 64'(a_ready), 64'd0);
            check("init_ready_b", 64'(b_ready), (i >= 16) ? 64'd1 : 64'd0);
            check("init_rd_data_a", a_rd_data, 64'd0);
            check("init_rd_busy_a", 64'(a_rd_busy), 64'd0);
            step();
        end
        check("ready_after_32", 64'(a_ready), 64'd1);
        a_we = 1'b0; a_iss_en = 1'b0;
        #1;
        check("reg5_cleared", 64'(a_rd_data[31:0]), 64'd0);
        check("reg5_not_busy", 64'(a_rd_busy), 64'd0);

        // Same-cycle bypass, then array read
        a_we = 1'b1; a_wraddr = 5'd7; a_wrdata = 32'h12345678;
        a_rs_addr = {5'd5, 5'd7};
        #1;
        check("bypass_p0", 64'(a_rd_data[31:0]), 64'h12345678);
        check("bypass_p1_other", 64'(a_rd_data[63:32]), 64'd0);
        step();
        a_we = 1'b0;
        #1;
        check("array_read_p0", 64'(a_rd_data[31:0]), 64'h12345678);

        // Register 0 hardwired
        a_we = 1'b1; a_wraddr = 5'd0; a_wrdata = 32'hFFFFFFFF;
        a_rs_addr = {5'd0, 5'd0};
        #1;
        check("zero_bypass", a_rd_data, 64'd0);
        step();
        a_we = 1'b0; a_iss_en = 1'b1; a_iss_rd = 5'd0;
        #1;
        check("zero_after_write", a_rd_data, 64'd0);
        step();
        a_iss_en = 1'b0;
        #1;
        check("zero_never_busy", 64'(a_rd_busy), 64'd0);

        // Issue then writeback hides the hazard
        a_iss_en = 1'b1; a_iss_rd = 5'd3;
        step();
        a_iss_en = 1'b0;
        a_rs_addr = {5'd7, 5'd3};
        #1;
        check("busy_after_issue", 64'(a_rd_busy), 64'h1);
        a_we = 1'b1; a_wraddr = 5'd3; a_wrdata = 32'hAAAA5555;
        #1;
        check("busy_hidden_by_wb", 64'(a_rd_busy), 64'h0);
        check("wb_bypass_p0", 64'(a_rd_data[31:0]), 64'hAAAA5555);
        step();
        a_we = 1'b0;
        #1;
        check("busy_cleared_by_wb", 64'(a_rd_busy), 64'h0);
        check("wb_array_p0", 64'(a_rd_data[31:0]), 64'hAAAA5555);

        // Set wins over same-edge clear; flush wins over issue
        a_iss_en = 1'b1; a_iss_rd = 5'd4;
        a_we = 1'b1; a_wraddr = 5'd4; a_wrdata = 32'h44;
        step();
        a_we = 1'b0; a_iss_rd = 5'd7;
        step();
        a_iss_en = 1'b0;
        a_rs_addr = {5'd7, 5'd4};
        #1;
        check("set_wins_and_second_issue", 64'(a_rd_busy), 64'h3);
        check("wb_data_r4", 64'(a_rd_data[31:0]), 64'h44);
        a_flush = 1'b1; a_iss_en = 1'b1; a_iss_rd = 5'd6;
        step();
        a_flush = 1'b0; a_iss_en = 1'b0;
        #1;
        check("flush_clears_4_7", 64'(a_rd_busy), 64'h0);
        a_rs_addr = {5'd6, 5'd3};
        #1;
        check("flush_beats_issue", 64'(a_rd_busy), 64'h0);

        // Wide configuration: four ports at once
        check("b_ready_run", 64'(b_ready), 64'd1);
        for (int r = 1; r <= 4; r++) begin
            b_we = 1'b1; b_wraddr = 4'(r);
            b_wrdata = 64'h0123_4567_89AB_CDE0 + 64'(r);
            step();
        end
        b_we = 1'b0;
        b_rs_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        check("b_port0", b_rd_data[63:0],    64'h0123_4567_89AB_CDE1);
        check("b_port1", b_rd_data[127:64],  64'h0123_4567_89AB_CDE2);
        check("b_port2", b_rd_data[191:128], 64'h0123_4567_89AB_CDE3);
        check("b_port3", b_rd_data[255:192], 64'h0123_4567_89AB_CDE4);
        b_we = 1'b1; b_wraddr = 4'd3; b_wrdata = 64'hFEED_FACE_CAFE_BEEF;
        #1;
        check("b_port2_bypass", b_rd_data[191:128], 64'hFEED_FACE_CAFE_BEEF);
        check("b_port1_unaffected", b_rd_data[127:64], 64'h0123_4567_89AB_CDE2);
        b_we = 1'b0;

        // Mid-run reset drops ready asynchronously and restarts a 16-cycle sweep
        #2;
        b_rst_n = 1'b0;
        #1;
        check("b_async_ready_drop", 64'(b_ready), 64'd0);
        check("b_reset_data_zero", b_rd_data[63:0], 64'd0);
        step();
        b_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("b_resweep_ready", 64'(b_ready), 64'd0);
            step();
        end
        check("b_ready_after_16", 64'(b_ready), 64'd1);
        check("b_reg1_swept", b_rd_data[63:0], 64'd0);
        check("b_reg4_swept", b_rd_data[255:192], 64'd0);
        check("a_unaffected_ready", 64'(a_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
